jump_input_decoder: RTL and testbench
=====================================

// Module: jump_input_decoder
// PURPOSE
//  Input-side counterpart to the VGA/audio output path: conditions the four raw
//  jump buttons (jumpForwardIn/BackwardIn/RightIn/LeftIn) into clean move commands.
//  Synchronises, debounces, edge-detects and auto-repeats each button, then hands
//  one direction at a time to the frog-position logic over a valid/ready handshake.
//  Also exports the debounced button levels, which feed topAudio.
// PARAMETERS
//  DEBOUNCE_CYCLES     251_000    stable cycles needed to accept a level change (10 ms @ 25.1 MHz)
//  HOLD_REPEAT_CYCLES  6_275_000  cycles a sole held button must stay down before a repeat move (250 ms)
//  CNT_W               23         counter width; must hold max(DEBOUNCE_CYCLES, HOLD_REPEAT_CYCLES)
// PORTS
//  clk             in   1  pixel clock, 25.1 MHz (PLL outglobal)
//  reset           in   1  asynchronous, active-high
//  jumpForwardIn   in   1  raw button, asynchronous, active-high
//  jumpBackwardIn  in   1  raw button, asynchronous, active-high
//  jumpRightIn     in   1  raw button, asynchronous, active-high
//  jumpLeftIn      in   1  raw button, asynchronous, active-high
//  move_valid      out  1  a move command is pending
//  move_dir        out  2  pending direction (dir_t); stable while move_valid=1
//  move_ready      in   1  consumer accepts the command when asserted with move_valid
//  btn_level       out  4  debounced levels {left,right,back,fwd}
// BEHAVIOUR
//  - Reset (async): sync FFs, stable levels, counters = 0; move_valid=0, move_dir=DIR_FWD,
//    btn_level=4'b0000, FSM=IDLE. Reset wins over all other events.
//  - Sync: 2-FF synchroniser per button; the raw input reaches the sync output 2 clk later.
//  - Debounce, per button: cnt clears whenever sync==stable; otherwise it increments.
//    Once sync!=stable is seen with cnt==DEBOUNCE_CYCLES-1, stable<=sync and cnt<=0.
//    A glitch shorter than DEBOUNCE_CYCLES never changes stable.
//  - Press event: a registered 0->1 change of stable produces a 1-cycle press pulse.
//  - Auto-repeat: rpt_cnt counts while exactly one stable bit is high. When it reaches
//    HOLD_REPEAT_CYCLES-1 it emits a repeat pulse for that button and wraps to 0.
//    It clears on any change of stable and whenever 0 or 2+ buttons are held.
//  - Arbitration: simultaneous pulses resolve as FWD > BACK > RIGHT > LEFT.
//    The losing pulses are discarded.
//  - FSM IDLE: if any pulse is present, latch the winning dir and set move_valid=1
//    on the next edge, then go to PENDING.
//  - FSM PENDING: move_valid and move_dir hold. When move_ready=1, the next edge
//    clears move_valid and the FSM returns to IDLE. Pulses arriving in PENDING
//    (including the accept cycle) are dropped: no queueing, no back-to-back moves.
//  - move_ready is ignored while move_valid=0.
//  - Latency: raw press -> move_valid = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) + 1 (FSM)
//    cycles, with DEBOUNCE_CYCLES+4 as the exact bound the bench checks.
//  - A release never generates a move.
//  - A button held through reset deassertion is treated as a new press and yields
//    one move after debounce.
//  - Counters never wrap on their own: debounce cnt is bounded by its clear rule;
//    rpt_cnt wraps only at HOLD_REPEAT_CYCLES-1.
// STRUCTURE
//  - Package frogger_pkg: typedef enum logic[1:0] dir_t {DIR_FWD=0, DIR_BACK=1,
//    DIR_RIGHT=2, DIR_LEFT=3}; typedef enum logic {ST_IDLE, ST_PENDING} jump_state_t.
//  - Sub-module debounce_cell (sync + debounce + press pulse), instantiated 4x.
//  - Repeat counter, priority arbiter and handshake FSM live in this module.
//  - top instantiates this block between the jump*In pins and the game/audio logic.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_REPEAT_CYCLES=16, move_ready=1 unless stated)
//  1. Raise jumpRightIn at cycle 0 and hold it -> btn_level=4'b0100 by cycle 6;
//     one move_valid pulse with move_dir=2 at cycle <=8.
//  2. Toggle jumpLeftIn at a 2-cycle period for 40 cycles -> btn_level[3] stays 0
//     and move_valid never asserts.
//  3. Raise fwd+left in the same cycle -> a single move with move_dir=0; no left move follows.
//  4. Hold move_ready=0, press back, then press right 10 cycles later ->
//     move_valid stays 1 with move_dir=1 until move_ready rises; the right press is dropped.
//  5. Hold jumpForwardIn for 60 cycles -> the initial move, then repeat moves
//     spaced 16 cycles apart. Adding back mid-hold stops the repeats.
//  6. Assert reset while move_valid=1 and a button is held -> move_valid=0,
//     btn_level=0 immediately (async). After release of reset: one move after debounce.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types for the frog jump input path: move directions and handshake states.
// Also carries the small helpers used by the arbiter and repeat logic.
package frogger_pkg;

    typedef enum logic [1:0] {
        DIR_FWD   = 2'd0,
        DIR_BACK  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } jump_state_t;

    // Fixed priority: fwd beats back beats right beats left.
    function automatic dir_t pick_dir(input logic [3:0] p);
        dir_t d;
        if (p[0])      d = DIR_FWD;
        else if (p[1]) d = DIR_BACK;
        else if (p[2]) d = DIR_RIGHT;
        else           d = DIR_LEFT;
        return d;
    endfunction

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/jump_input_decoder_debounce_cell.sv
// One button lane: 2-FF synchroniser, counter debounce and registered press pulse.
// The pulse fires one cycle after the debounced level rises.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 251_000,
    parameter int CNT_W           = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_sync;
    logic             r_stable;
    logic             r_prev;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_prev   <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1    <= i_raw;
            r_sync  <= r_s1;
            r_prev  <= r_stable;
            r_press <= r_stable & ~r_prev;
            // Any return to the stable level restarts the qualification window.
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_press = r_press;

endmodule

// File: rtl/jump_input_decoder.sv
// Turns four raw jump buttons into single move commands with auto-repeat,
// offered one at a time to the frog-position logic over valid/ready.
module jump_input_decoder
    import frogger_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 251_000,
    parameter int HOLD_REPEAT_CYCLES = 6_275_000,
    parameter int CNT_W              = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jumpForwardIn,
    input  logic       jumpBackwardIn,
    input  logic       jumpRightIn,
    input  logic       jumpLeftIn,
    output logic       move_valid,
    output dir_t       move_dir,
    input  logic       move_ready,
    output logic [3:0] btn_level
);

    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(HOLD_REPEAT_CYCLES - 1);

    logic [3:0]       w_raw;
    logic [3:0]       w_lvl;
    logic [3:0]       w_press;
    logic [3:0]       w_pulse;
    logic             w_one;
    logic             w_chg;
    logic [3:0]       r_lvl_prev;
    logic [3:0]       r_rpt;
    logic [CNT_W-1:0] r_rpt_cnt;
    jump_state_t      r_state;
    jump_state_t      w_state_nxt;
    dir_t             r_dir;
    dir_t             w_dir_nxt;

    assign w_raw = {jumpLeftIn, jumpRightIn, jumpBackwardIn, jumpForwardIn};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (w_raw[g]),
            .o_level(w_lvl[g]),
            .o_press(w_press[g])
        );
    end

    assign w_one = is_one_hot(w_lvl);
    assign w_chg = (w_lvl != r_lvl_prev);

    // Repeat only while a single button is held; any level change restarts the hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lvl_prev <= 4'b0000;
            r_rpt      <= 4'b0000;
            r_rpt_cnt  <= '0;
        end else begin
            r_lvl_prev <= w_lvl;
            r_rpt      <= 4'b0000;
            if (w_chg || !w_one) begin
                r_rpt_cnt <= '0;
            end else if (r_rpt_cnt == RPT_LAST) begin
                r_rpt_cnt <= '0;
                r_rpt     <= w_lvl;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
        end
    end

    assign w_pulse = w_press | r_rpt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_FWD;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Pulses seen while a command is outstanding are dropped, not queued.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        unique case (r_state)
            ST_IDLE: begin
                if (|w_pulse) begin
                    w_state_nxt = ST_PENDING;
                    w_dir_nxt   = pick_dir(w_pulse);
                end
            end
            ST_PENDING: begin
                if (move_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign move_valid = (r_state == ST_PENDING);
    assign move_dir   = r_dir;
    assign btn_level  = w_lvl;

endmodule

// File: tb/tb_jump_input_decoder.sv
// Directed bench for jump_input_decoder with short debounce/repeat windows.
// Each step drives buttons, watches the handshake and asserts on the outcome.
module tb_jump_input_decoder;
    import frogger_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fwd = 1'b0;
    logic       back = 1'b0;
    logic       right = 1'b0;
    logic       left = 1'b0;
    logic       ready = 1'b1;
    logic       valid;
    dir_t       dir;
    logic [3:0] lvl;

    int n_cmp = 0;
    int n_bad = 0;
    int pos[$];
    int lvl_first;

    jump_input_decoder #(
        .DEBOUNCE_CYCLES   (4),
        .HOLD_REPEAT_CYCLES(16),
        .CNT_W             (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .jumpForwardIn (fwd),
        .jumpBackwardIn(back),
        .jumpRightIn   (right),
        .jumpLeftIn    (left),
        .move_valid    (valid),
        .move_dir      (dir),
        .move_ready    (ready),
        .btn_level     (lvl)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts valid cycles over n clocks; records cycle indices and dirs seen.
    task automatic watch(input int n, input logic [3:0] lvl_tgt,
                         output int cnt, output int first, output int dmask);
        cnt = 0;
        first = 0;
        dmask = 0;
        lvl_first = 0;
        pos.delete();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (lvl_first == 0 && lvl === lvl_tgt) lvl_first = k;
            if (valid === 1'b1) begin
                cnt++;
                if (first == 0) first = k;
                dmask = dmask | (1 << int'(dir));
                pos.push_back(k);
            end
        end
    endtask

    initial begin
        int cnt, first, dm;
        logic seen_l, seen_v;

        tick(2);
        chk("rst_valid", valid, 1'b0);
        chk("rst_dir", dir, DIR_FWD);
        chk("rst_level", lvl, 4'b0000);
        reset = 1'b0;
        tick(3);

        // 1: single right press
        right = 1'b1;
        watch(12, 4'b0100, cnt, first, dm);
        chk("t1_level_by6", (lvl_first >= 1 && lvl_first <= 6), 1);
        chk("t1_move_by8", (first >= 1 && first <= 8), 1);
        chk("t1_move_count", cnt, 1);
        chk("t1_move_dir", dm, 32'h4);
        right = 1'b0;
        watch(14, 4'b0000, cnt, first, dm);
        chk("t1_release_nomove", cnt, 0);
        chk("t1_release_level", lvl, 4'b0000);

        // 2: fast-toggling left is rejected
        seen_l = 1'b0;
        seen_v = 1'b0;
        for (int k = 0; k < 40; k++) begin
            left = ~left;
            tick();
            if (lvl[3] === 1'b1) seen_l = 1'b1;
            if (valid === 1'b1) seen_v = 1'b1;
        end
        left = 1'b0;
        tick(8);
        chk("t2_left_level", seen_l, 1'b0);
        chk("t2_no_move", seen_v, 1'b0);

        // 3: simultaneous fwd+left
        fwd = 1'b1;
        left = 1'b1;
        watch(30, 4'b1001, cnt, first, dm);
        chk("t3_move_count", cnt, 1);
        chk("t3_dir_fwd_only", dm, 32'h1);
        chk("t3_level", lvl, 4'b1001);
        fwd = 1'b0;
        left = 1'b0;
        watch(12, 4'b0000, cnt, first, dm);
        chk("t3_release_nomove", cnt, 0);

        // 4: backpressure holds the command, later press dropped
        ready = 1'b0;
        back = 1'b1;
        watch(10, 4'b0010, cnt, first, dm);
        chk("t4_move_by8", (first >= 1 && first <= 8), 1);
        right = 1'b1;
        watch(20, 4'b0110, cnt, first, dm);
        chk("t4_valid_held", cnt, 20);
        chk("t4_dir_back", dm, 32'h2);
        ready = 1'b1;
        tick();
        chk("t4_accept_clears", valid, 1'b0);
        watch(20, 4'b0110, cnt, first, dm);
        chk("t4_right_dropped", cnt, 0);
        back = 1'b0;
        right = 1'b0;
        watch(12, 4'b0000, cnt, first, dm);
        chk("t4_release_nomove", cnt, 0);

        // 5: auto-repeat while fwd alone is held
        fwd = 1'b1;
        watch(60, 4'b0001, cnt, first, dm);
        chk("t5_move_count", cnt, 4);
        chk("t5_dir", dm, 32'h1);
        chk("t5_first_by8", (first >= 1 && first <= 8), 1);
        chk("t5_gap1", (pos.size() >= 2) ? pos[1] - pos[0] : -1, 16);
        chk("t5_gap2", (pos.size() >= 3) ? pos[2] - pos[1] : -1, 16);
        back = 1'b1;
        watch(40, 4'b0011, cnt, first, dm);
        chk("t5_back_count", cnt, 1);
        chk("t5_back_dir", dm, 32'h2);
        fwd = 1'b0;
        back = 1'b0;
        watch(12, 4'b0000, cnt, first, dm);
        chk("t5_release_nomove", cnt, 0);

        // 6: async reset with a pending command and held button
        ready = 1'b0;
        fwd = 1'b1;
        tick(10);
        chk("t6_pre_valid", valid, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", valid, 1'b0);
        chk("t6_async_level", lvl, 4'b0000);
        tick();
        reset = 1'b0;
        watch(10, 4'b0001, cnt, first, dm);
        chk("t6_move_by8", (first >= 1 && first <= 8), 1);
        chk("t6_dir", dm, 32'h1);
        ready = 1'b1;
        tick();
        chk("t6_accept", valid, 1'b0);
        fwd = 1'b0;
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
